// File: rtl/fir_tdm_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed FIR filter.
// The output scaling is done at a fixed wide width so any legal ACC_W/OUT_W combination fits.
package fir_tdm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    localparam int RS_W = 128;

    typedef logic signed [RS_W-1:0] rs_wide_t;

    typedef struct packed {
        logic signed [RS_W-1:0] value;
        logic                   sat;
    } rs_result_t;

    function automatic int calc_k_w(input int taps);
        return $clog2(taps);
    endfunction

    function automatic int calc_ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int calc_acc_w(input int x_w, input int h_w, input int taps);
        return x_w + h_w + $clog2(taps);
    endfunction

    // Round half up, arithmetic shift, then clip to the signed out_w range.
    function automatic rs_result_t round_sat(input rs_wide_t acc, input int shift, input int out_w);
        rs_wide_t   r;
        rs_wide_t   hi;
        rs_wide_t   lo;
        rs_result_t res;
        r = acc;
        if (shift > 0) begin
            r = acc + (rs_wide_t'(1) <<< (shift - 1));
        end
        r  = r >>> shift;
        hi = (rs_wide_t'(1) <<< (out_w - 1)) - rs_wide_t'(1);
        lo = -(rs_wide_t'(1) <<< (out_w - 1));
        res.value = r;
        res.sat   = 1'b0;
        if (r > hi) begin
            res.value = hi;
            res.sat   = 1'b1;
        end else if (r < lo) begin
            res.value = lo;
            res.sat   = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Registered signed multiplier feeding an accumulator.
// o_acc is the running sum including the product currently held in the multiplier register.
module fir_mac_unit
    import fir_tdm_pkg::*;
#(
    parameter int X_W   = 24,
    parameter int H_W   = 16,
    parameter int ACC_W = 44
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_clr,
    input  logic                    i_mul_en,
    input  logic                    i_acc_en,
    input  logic signed [X_W-1:0]   i_x,
    input  logic signed [H_W-1:0]   i_h,
    output logic signed [ACC_W-1:0] o_acc
);
    localparam int P_W = X_W + H_W;

    logic signed [P_W-1:0]   r_prod;
    logic signed [P_W-1:0]   w_x_ext;
    logic signed [P_W-1:0]   w_h_ext;
    logic signed [ACC_W-1:0] r_acc;

    assign w_x_ext = {{H_W{i_x[X_W-1]}}, i_x};
    assign w_h_ext = {{X_W{i_h[H_W-1]}}, i_h};
    assign o_acc   = r_acc + {{(ACC_W-P_W){r_prod[P_W-1]}}, r_prod};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prod <= '0;
            r_acc  <= '0;
        end else begin
            if (i_mul_en) begin
                r_prod <= w_x_ext * w_h_ext;
            end
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_acc_en) begin
                r_acc <= o_acc;
            end
        end
    end

endmodule

// File: rtl/fir_tdm_filter.sv
// Multi-channel FIR sharing one MAC over TAPS cycles per sample.
// Each channel keeps its own circular history; coefficients are common to all channels.
module fir_tdm_filter
    import fir_tdm_pkg::*;
#(
    parameter int TAPS     = 16,
    parameter int CHANNELS = 2,
    parameter int X_W      = 24,
    parameter int H_W      = 16,
    parameter int OUT_W    = 24,
    parameter int SHIFT    = 15,
    localparam int ACC_W   = calc_acc_w(X_W, H_W, TAPS),
    localparam int CH_W    = calc_ch_w(CHANNELS),
    localparam int K_W     = calc_k_w(TAPS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [X_W-1:0]   s_data,
    input  logic [CH_W-1:0]         s_chan,
    input  logic                    coef_we,
    output logic                    coef_ready,
    input  logic [K_W-1:0]          coef_addr,
    input  logic signed [H_W-1:0]   coef_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [OUT_W-1:0] m_data,
    output logic [CH_W-1:0]         m_chan,
    output logic                    m_sat
);
    state_t                  r_state;
    logic [K_W:0]            r_k;
    logic [K_W-1:0]          r_newest;
    logic [CH_W-1:0]         r_chan;
    logic                    r_m_valid;
    logic signed [OUT_W-1:0] r_m_data;
    logic [CH_W-1:0]         r_m_chan;
    logic                    r_m_sat;
    logic signed [H_W-1:0]   r_coef [TAPS];

    logic                    w_idle;
    logic                    w_chan_ok;
    logic                    w_take;
    logic                    w_coef_wr;
    logic [K_W-1:0]          w_tap;
    logic [K_W-1:0]          w_idx;
    logic signed [X_W-1:0]   w_x;
    logic signed [X_W-1:0]   w_ch_x [CHANNELS];
    logic [K_W-1:0]          w_ch_wptr [CHANNELS];
    logic signed [ACC_W-1:0] w_acc;
    rs_wide_t                w_acc_wide;
    rs_result_t              w_rs;
    logic signed [OUT_W-1:0] w_rs_data;
    logic [RS_W-OUT_W-1:0]   w_rs_msbs_unused;

    assign w_idle     = (r_state == IDLE);
    assign w_chan_ok  = ({1'b0, s_chan} < (CH_W+1)'(CHANNELS));
    assign w_take     = s_valid && w_idle && w_chan_ok;
    assign w_coef_wr  = coef_we && w_idle && ({1'b0, coef_addr} < (K_W+1)'(TAPS));

    // Tap j reads the sample j steps older than the newest one, modulo TAPS.
    assign w_tap = r_k[K_W-1:0];
    assign w_idx = (r_newest >= w_tap) ? (r_newest - w_tap)
                                       : K_W'(TAPS + int'(r_newest) - int'(w_tap));

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic signed [X_W-1:0] r_hist [TAPS];
        logic [K_W-1:0]        r_wptr;
        logic                  w_wr;

        assign w_wr = w_take && (s_chan == CH_W'(gi));

        always_ff @(posedge clk) begin
            if (reset) begin
                r_wptr <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    r_hist[t] <= '0;
                end
            end else if (w_wr) begin
                r_hist[r_wptr] <= s_data;
                r_wptr         <= (r_wptr == K_W'(TAPS - 1)) ? '0 : r_wptr + K_W'(1);
            end
        end

        assign w_ch_x[gi]    = r_hist[w_idx];
        assign w_ch_wptr[gi] = r_wptr;
    end

    assign w_x = w_ch_x[r_chan];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < TAPS; t++) begin
                r_coef[t] <= '0;
            end
        end else if (w_coef_wr) begin
            r_coef[coef_addr] <= coef_data;
        end
    end

    fir_mac_unit #(
        .X_W   (X_W),
        .H_W   (H_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_take),
        .i_mul_en ((r_state == MAC) && (r_k < (K_W+1)'(TAPS))),
        .i_acc_en ((r_state == MAC) && (r_k != '0)),
        .i_x      (w_x),
        .i_h      (r_coef[w_tap]),
        .o_acc    (w_acc)
    );

    assign w_acc_wide = {{(RS_W-ACC_W){w_acc[ACC_W-1]}}, w_acc};
    assign w_rs       = round_sat(w_acc_wide, SHIFT, OUT_W);
    // After saturation the upper bits are only a sign extension of w_rs_data.
    assign {w_rs_msbs_unused, w_rs_data} = w_rs.value;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_newest  <= '0;
            r_chan    <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_chan  <= '0;
            r_m_sat   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_chan   <= s_chan;
                        r_newest <= w_ch_wptr[s_chan];
                        r_k      <= '0;
                        r_state  <= MAC;
                    end
                end
                MAC: begin
                    r_k <= r_k + (K_W+1)'(1);
                    // Final cycle: the last product joins the sum and the result is registered.
                    if (r_k == (K_W+1)'(TAPS)) begin
                        r_state   <= OUT;
                        r_m_valid <= 1'b1;
                        r_m_data  <= w_rs_data;
                        r_m_sat   <= w_rs.sat;
                        r_m_chan  <= r_chan;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        r_state   <= IDLE;
                        r_m_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_ready    = w_idle;
    assign coef_ready = w_idle;
    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign m_chan     = r_m_chan;
    assign m_sat      = r_m_sat;

endmodule

// File: tb/tb_fir_tdm_filter.sv
// Directed bench for fir_tdm_filter: two 4-tap instances share stimulus, SHIFT=0 (a) and SHIFT=1 (b).
module tb_fir_tdm_filter;
    localparam int TAPS  = 4;
    localparam int X_W   = 24;
    localparam int H_W   = 16;
    localparam int OUT_W = 24;
    localparam int CH_W  = 1;
    localparam int K_W   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    reset;
    logic                    s_valid;
    logic signed [X_W-1:0]   s_data;
    logic [CH_W-1:0]         s_chan;
    logic                    coef_we;
    logic [K_W-1:0]          coef_addr;
    logic signed [H_W-1:0]   coef_data;
    logic                    m_ready;

    logic                    a_s_ready, a_coef_ready, a_m_valid, a_m_sat;
    logic signed [OUT_W-1:0] a_m_data;
    logic [CH_W-1:0]         a_m_chan;
    logic                    b_s_ready, b_coef_ready, b_m_valid, b_m_sat;
    logic signed [OUT_W-1:0] b_m_data;
    logic [CH_W-1:0]         b_m_chan;

    int checks   = 0;
    int failures = 0;

    fir_tdm_filter #(.TAPS(TAPS), .CHANNELS(2), .X_W(X_W), .H_W(H_W), .OUT_W(OUT_W), .SHIFT(0)) dut_a (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data),
        .s_chan(s_chan), .coef_we(coef_we), .coef_ready(a_coef_ready), .coef_addr(coef_addr),
        .coef_data(coef_data), .m_valid(a_m_valid), .m_ready(m_ready), .m_data(a_m_data),
        .m_chan(a_m_chan), .m_sat(a_m_sat)
    );

    fir_tdm_filter #(.TAPS(TAPS), .CHANNELS(2), .X_W(X_W), .H_W(H_W), .OUT_W(OUT_W), .SHIFT(1)) dut_b (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data),
        .s_chan(s_chan), .coef_we(coef_we), .coef_ready(b_coef_ready), .coef_addr(coef_addr),
        .coef_data(coef_data), .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data),
        .m_chan(b_m_chan), .m_sat(b_m_sat)
    );

    task automatic do_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic load_coefs(input int h0, input int h1, input int h2, input int h3);
        int h [4];
        h = '{h0, h1, h2, h3};
        for (int k = 0; k < 4; k++) begin
            coef_we   = 1'b1;
            coef_addr = K_W'(k);
            coef_data = H_W'(h[k]);
            @(posedge clk);
            #1;
        end
        coef_we = 1'b0;
    endtask

    // Sends one sample, waits for m_valid and returns the outputs; completes the handshake if m_ready=1.
    // lat counts cycles from the accept cycle (cycle 0) to the first cycle with m_valid high.
    task automatic run_sample(input int x, input int ch,
                              output logic signed [OUT_W-1:0] ad, output logic [CH_W-1:0] ac,
                              output logic asat, output logic signed [OUT_W-1:0] bd,
                              output logic bsat, output int lat);
        int  n;
        bit  got;
        n = 0;
        while (!a_s_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!a_s_ready) begin
            checks++;
            failures++;
            $display("FAIL s_ready_timeout got=0 exp=1");
        end
        s_data  = X_W'(x);
        s_chan  = CH_W'(ch);
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_m_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL m_valid_timeout got=0 exp=1");
        end
        ad   = a_m_data;
        ac   = a_m_chan;
        asat = a_m_sat;
        bd   = b_m_data;
        bsat = b_m_sat;
        if (m_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        do_reset();
        @(negedge clk);
        checks++;
        if (a_s_ready !== 1'b1 || a_coef_ready !== 1'b1 || b_s_ready !== 1'b1 || b_coef_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b%b%b%b exp=1111", a_s_ready, a_coef_ready, b_s_ready, b_coef_ready);
        end
        checks++;
        if (a_m_valid !== 1'b0 || b_m_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_m_valid got=%b%b exp=00", a_m_valid, b_m_valid);
        end
        checks++;
        if (a_m_data !== '0 || a_m_chan !== '0 || a_m_sat !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got data=%0d chan=%0d sat=%b exp=0 0 0", a_m_data, a_m_chan, a_m_sat);
        end
    endtask

    task automatic test_impulse;
        int exp_a [5] = '{1, 2, 3, 4, 0};
        int xin   [5] = '{1, 0, 0, 0, 0};
        logic signed [OUT_W-1:0] ad, bd;
        logic [CH_W-1:0] ac;
        logic asat, bsat;
        int lat;
        do_reset();
        load_coefs(1, 2, 3, 4);
        for (int i = 0; i < 5; i++) begin
            run_sample(xin[i], 0, ad, ac, asat, bd, bsat, lat);
            $display("impulse[%0d] x=%0d y=%0d sat=%b lat=%0d", i, xin[i], ad, asat, lat);
            checks++;
            if (ad !== OUT_W'(exp_a[i])) begin
                failures++;
                $display("FAIL impulse_data[%0d] got=%0d exp=%0d", i, ad, exp_a[i]);
            end
            checks++;
            if (asat !== 1'b0) begin
                failures++;
                $display("FAIL impulse_sat[%0d] got=%b exp=0", i, asat);
            end
            checks++;
            if (lat != TAPS + 2) begin
                failures++;
                $display("FAIL impulse_latency[%0d] got=%0d exp=%0d", i, lat, TAPS + 2);
            end
        end
    endtask

    task automatic test_channels;
        int xin   [3] = '{10, 5, 10};
        int chs   [3] = '{0, 1, 0};
        int exp_a [3] = '{10, 5, 20};
        logic signed [OUT_W-1:0] ad, bd;
        logic [CH_W-1:0] ac;
        logic asat, bsat;
        int lat;
        do_reset();
        load_coefs(1, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            run_sample(xin[i], chs[i], ad, ac, asat, bd, bsat, lat);
            $display("channels[%0d] ch=%0d x=%0d y=%0d m_chan=%0d", i, chs[i], xin[i], ad, ac);
            checks++;
            if (ad !== OUT_W'(exp_a[i])) begin
                failures++;
                $display("FAIL chan_data[%0d] got=%0d exp=%0d", i, ad, exp_a[i]);
            end
            checks++;
            if (ac !== CH_W'(chs[i])) begin
                failures++;
                $display("FAIL chan_id[%0d] got=%0d exp=%0d", i, ac, chs[i]);
            end
        end
    endtask

    task automatic test_saturation;
        int xin [2] = '{8388607, -8388608};
        int exp [2] = '{8388607, -8388608};
        logic signed [OUT_W-1:0] ad, bd;
        logic [CH_W-1:0] ac;
        logic asat, bsat;
        int lat;
        do_reset();
        load_coefs(32767, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            run_sample(xin[i], 0, ad, ac, asat, bd, bsat, lat);
            $display("saturation[%0d] x=%0d ya=%0d sa=%b yb=%0d sb=%b", i, xin[i], ad, asat, bd, bsat);
            checks++;
            if (ad !== OUT_W'(exp[i]) || asat !== 1'b1) begin
                failures++;
                $display("FAIL sat_a[%0d] got=%0d/%b exp=%0d/1", i, ad, asat, exp[i]);
            end
            checks++;
            if (bd !== OUT_W'(exp[i]) || bsat !== 1'b1) begin
                failures++;
                $display("FAIL sat_b[%0d] got=%0d/%b exp=%0d/1", i, bd, bsat, exp[i]);
            end
        end
    endtask

    task automatic test_rounding;
        int xin   [2] = '{3, -3};
        int exp_b [2] = '{2, -1};
        logic signed [OUT_W-1:0] ad, bd;
        logic [CH_W-1:0] ac;
        logic asat, bsat;
        int lat;
        do_reset();
        load_coefs(1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            run_sample(xin[i], 0, ad, ac, asat, bd, bsat, lat);
            $display("rounding[%0d] x=%0d ya=%0d yb=%0d sb=%b", i, xin[i], ad, bd, bsat);
            checks++;
            if (bd !== OUT_W'(exp_b[i]) || bsat !== 1'b0) begin
                failures++;
                $display("FAIL round_b[%0d] got=%0d/%b exp=%0d/0", i, bd, bsat, exp_b[i]);
            end
            checks++;
            if (ad !== OUT_W'(xin[i])) begin
                failures++;
                $display("FAIL round_a[%0d] got=%0d exp=%0d", i, ad, xin[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic signed [OUT_W-1:0] ad, bd;
        logic [CH_W-1:0] ac;
        logic asat, bsat;
        int lat;
        bit got;
        do_reset();
        load_coefs(1, 2, 3, 4);
        m_ready = 1'b0;
        s_data  = X_W'(7);
        s_chan  = CH_W'(1);
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        coef_we   = 1'b1;
        coef_addr = '0;
        coef_data = H_W'(100);
        @(negedge clk);
        checks++;
        if (a_coef_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_coef_ready_mac got=%b exp=0", a_coef_ready);
        end
        @(posedge clk);
        #1 coef_we = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_m_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL bp_m_valid_timeout got=0 exp=1");
        end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            $display("backpressure[%0d] m_valid=%b y=%0d ch=%0d s_ready=%b", i, a_m_valid, a_m_data, a_m_chan, a_s_ready);
            checks++;
            if (a_m_valid !== 1'b1 || a_m_data !== OUT_W'(7) || a_m_chan !== CH_W'(1)) begin
                failures++;
                $display("FAIL bp_hold[%0d] got=%b/%0d/%0d exp=1/7/1", i, a_m_valid, a_m_data, a_m_chan);
            end
            checks++;
            if (a_s_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_s_ready[%0d] got=%b exp=0", i, a_s_ready);
            end
            if (i == 3) begin
                coef_we   = 1'b1;
                coef_addr = '0;
                coef_data = H_W'(55);
            end else if (i == 4) begin
                coef_we = 1'b0;
            end
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        run_sample(1, 0, ad, ac, asat, bd, bsat, lat);
        $display("backpressure_next x=1 y=%0d ch=%0d", ad, ac);
        checks++;
        if (ad !== OUT_W'(1) || ac !== CH_W'(0)) begin
            failures++;
            $display("FAIL bp_coef_lockout got=%0d/%0d exp=1/0", ad, ac);
        end
    endtask

    task automatic test_reset_mid;
        int exp_pre [3] = '{9, 27, 54};
        int exp_a   [4] = '{1, 2, 3, 4};
        int xin     [4] = '{1, 0, 0, 0};
        logic signed [OUT_W-1:0] ad, bd;
        logic [CH_W-1:0] ac;
        logic asat, bsat;
        int lat;
        do_reset();
        load_coefs(1, 2, 3, 4);
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) m_ready = 1'b0;
            run_sample(9, 0, ad, ac, asat, bd, bsat, lat);
            $display("reset_mid_pre[%0d] x=9 y=%0d", i, ad);
            checks++;
            if (ad !== OUT_W'(exp_pre[i])) begin
                failures++;
                $display("FAIL rm_pre[%0d] got=%0d exp=%0d", i, ad, exp_pre[i]);
            end
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (a_m_valid !== 1'b0 || a_s_ready !== 1'b1) begin
            failures++;
            $display("FAIL rm_out_abort got=%b/%b exp=0/1", a_m_valid, a_s_ready);
        end
        m_ready = 1'b1;
        s_data  = X_W'(9);
        s_chan  = '0;
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (a_m_valid !== 1'b0 || a_s_ready !== 1'b1) begin
            failures++;
            $display("FAIL rm_mac_abort got=%b/%b exp=0/1", a_m_valid, a_s_ready);
        end
        load_coefs(1, 2, 3, 4);
        for (int i = 0; i < 4; i++) begin
            run_sample(xin[i], 0, ad, ac, asat, bd, bsat, lat);
            $display("reset_mid_post[%0d] x=%0d y=%0d", i, xin[i], ad);
            checks++;
            if (ad !== OUT_W'(exp_a[i])) begin
                failures++;
                $display("FAIL rm_post[%0d] got=%0d exp=%0d", i, ad, exp_a[i]);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        s_chan    = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        m_ready   = 1'b1;
        test_reset();
        test_impulse();
        test_channels();
        test_saturation();
        test_rounding();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
